// File: rtl/msrv32_dmem_access_ctrl_pkg.sv
// Shared types and constants for the msrv32 data-memory access controller.
// Holds the FSM state encoding, the access size codes and the default bus timeout.
package msrv32_dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } dmemState_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/msrv32_dmem_access_ctrl_store_align.sv
// Combinational store alignment: derives byte enables, lane-replicated write data
// and the misaligned flag from access size and the low address bits.
module msrv32_store_align
    import msrv32_dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_laneData,
    output logic        o_misaligned
);

    always_comb begin
        o_mask       = 4'b1111;
        o_laneData   = i_wdata;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_mask     = 4'b0001 << i_addrLo;
                o_laneData = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_mask       = 4'b0011 << {i_addrLo[1], 1'b0};
                o_laneData   = {2{i_wdata[15:0]}};
                o_misaligned = i_addrLo[0];
            end
            default: begin
                o_mask       = 4'b1111;
                o_laneData   = i_wdata;
                o_misaligned = |i_addrLo;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// Data-memory access sequencer: one request at a time through ADDR and DATA bus phases,
// with timeout, error and misalignment reporting and a one-cycle response pulse.
module msrv32_dmem_access_ctrl
    import msrv32_dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    output logic        mem_req_ready_out,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic        ms_riscv32_mp_dmtrans_out,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    output logic [1:0]  lu_load_size_out,
    output logic        lu_load_unsigned_out,
    output logic [1:0]  lu_iadder_1_0_out,
    input  logic [31:0] lu_output_in,
    output logic        rsp_valid_out,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_err_out,
    output logic        rsp_misaligned_out,
    output logic        stall_out
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    dmemState_t  r_state;
    dmemState_t  w_nextState;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [TO_W-1:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_misaligned;

    logic        w_isIdle;
    logic        w_accept;
    logic        w_busPhase;
    logic        w_timeout;
    logic [1:0]  w_alSize;
    logic [1:0]  w_alAddrLo;
    logic [3:0]  w_mask;
    logic [31:0] w_laneData;
    logic        w_misaligned;

    assign w_isIdle   = (r_state == ST_IDLE);
    assign w_accept   = w_isIdle & mem_req_in;
    assign w_busPhase = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timeout  = !ahb_ready_in && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // In IDLE the aligner checks the incoming request; afterwards it works on latched fields.
    assign w_alSize   = w_isIdle ? mem_size_in     : r_size;
    assign w_alAddrLo = w_isIdle ? mem_addr_in[1:0] : r_addr[1:0];

    msrv32_store_align u_storeAlign (
        .i_size       (w_alSize),
        .i_addrLo     (w_alAddrLo),
        .i_wdata      (r_wdata),
        .o_mask       (w_mask),
        .o_laneData   (w_laneData),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) r_state <= ST_IDLE;
        else                         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = w_misaligned ? ST_RESP : ST_ADDR;
            ST_ADDR: w_nextState = ST_DATA;
            ST_DATA: if (ahb_ready_in || w_timeout) w_nextState = ST_RESP;
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we         <= mem_we_in;
                        r_size       <= mem_size_in;
                        r_unsigned   <= mem_unsigned_in;
                        r_addr       <= mem_addr_in;
                        r_wdata      <= mem_wdata_in;
                        r_cnt        <= '0;
                        r_rdata      <= '0;
                        r_err        <= w_misaligned;
                        r_misaligned <= w_misaligned;
                    end
                end
                ST_ADDR: r_cnt <= '0;
                ST_DATA: begin
                    // A ready arriving on the final allowed cycle takes priority over timeout.
                    if (ahb_ready_in) begin
                        r_err   <= ahb_resp_in;
                        r_rdata <= (!ahb_resp_in && !r_we) ? lu_output_in : 32'h0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    r_rdata      <= '0;
                    r_err        <= 1'b0;
                    r_misaligned <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_ready_out           = w_isIdle;
    assign stall_out                   = !w_isIdle;
    assign ms_riscv32_mp_dmtrans_out   = (r_state == ST_ADDR);
    assign ms_riscv32_mp_dmwr_req_out  = (r_state == ST_ADDR) && r_we;
    assign ms_riscv32_mp_dmaddr_out    = w_busPhase ? {r_addr[31:2], 2'b00} : 32'h0;
    assign ms_riscv32_mp_dmdata_out    = w_busPhase ? w_laneData : 32'h0;
    assign ms_riscv32_mp_dmwr_mask_out = (w_busPhase && r_we) ? w_mask : 4'b0000;

    assign lu_load_size_out     = r_size;
    assign lu_load_unsigned_out = r_unsigned;
    assign lu_iadder_1_0_out    = r_addr[1:0];

    assign rsp_valid_out      = (r_state == ST_RESP);
    assign rsp_rdata_out      = rsp_valid_out ? r_rdata      : 32'h0;
    assign rsp_err_out        = rsp_valid_out ? r_err        : 1'b0;
    assign rsp_misaligned_out = rsp_valid_out ? r_misaligned : 1'b0;

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// Self-checking bench for msrv32_dmem_access_ctrl: table-driven transactions plus
// hand-written timeout and mid-transfer reset sequences, with a behavioural load unit.
module tb_msrv32_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        memReq, memWe, memUnsigned;
    logic [1:0]  memSize;
    logic [31:0] memAddr, memWdata;
    logic        memReady;
    logic [31:0] dmAddr, dmData;
    logic [3:0]  dmMask;
    logic        dmWrReq, dmTrans;
    logic        ahbReady, ahbResp;
    logic [1:0]  luSize, luAddrLo;
    logic        luUnsigned;
    logic [31:0] luOutput;
    logic        rspValid, rspErr, rspMis, stall;
    logic [31:0] rspRdata;
    logic [31:0] busRdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msrv32_dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_n_in      (rstN),
        .mem_req_in                  (memReq),
        .mem_we_in                   (memWe),
        .mem_size_in                 (memSize),
        .mem_unsigned_in             (memUnsigned),
        .mem_addr_in                 (memAddr),
        .mem_wdata_in                (memWdata),
        .mem_req_ready_out           (memReady),
        .ms_riscv32_mp_dmaddr_out    (dmAddr),
        .ms_riscv32_mp_dmdata_out    (dmData),
        .ms_riscv32_mp_dmwr_mask_out (dmMask),
        .ms_riscv32_mp_dmwr_req_out  (dmWrReq),
        .ms_riscv32_mp_dmtrans_out   (dmTrans),
        .ahb_ready_in                (ahbReady),
        .ahb_resp_in                 (ahbResp),
        .lu_load_size_out            (luSize),
        .lu_load_unsigned_out        (luUnsigned),
        .lu_iadder_1_0_out           (luAddrLo),
        .lu_output_in                (luOutput),
        .rsp_valid_out               (rspValid),
        .rsp_rdata_out               (rspRdata),
        .rsp_err_out                 (rspErr),
        .rsp_misaligned_out          (rspMis),
        .stall_out                   (stall)
    );

    // Stand-in for msrv32_load_unit: extracts and extends the addressed lane of the bus data.
    logic [31:0] luShift;
    always_comb begin
        luShift  = busRdata;
        luOutput = busRdata;
        case (luSize)
            2'b00: begin
                luShift  = busRdata >> {luAddrLo, 3'b000};
                luOutput = luUnsigned ? {24'h0, luShift[7:0]} : {{24{luShift[7]}}, luShift[7:0]};
            end
            2'b01: begin
                luShift  = busRdata >> {luAddrLo[1], 4'b0000};
                luOutput = luUnsigned ? {16'h0, luShift[15:0]} : {{16{luShift[15]}}, luShift[15:0]};
            end
            default: luOutput = busRdata;
        endcase
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus;
        int          waits;
        logic        resp;
        logic [3:0]  expMask;
        logic [31:0] expDmdata;
        logic [31:0] expRdata;
        logic        expErr;
        logic        expMis;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] bus, int w, logic resp,
                                logic [3:0] m, logic [31:0] dd, logic [31:0] rd, logic e, logic mis);
        vec_t v;
        v.name = n; v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.bus = bus;
        v.waits = w; v.resp = resp; v.expMask = m; v.expDmdata = dd; v.expRdata = rd;
        v.expErr = e; v.expMis = mis;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        checkOutput({v.name, " idle ready"}, 32'(memReady), 32'd1);
        memReq = 1'b1; memWe = v.we; memSize = v.size; memUnsigned = v.uns;
        memAddr = v.addr; memWdata = v.wdata; busRdata = v.bus;
        step();
        memReq = 1'b0;
        checkOutput({v.name, " lu size"}, 32'(luSize), 32'(v.size));
        checkOutput({v.name, " lu addrlo"}, 32'(luAddrLo), 32'(v.addr[1:0]));
        if (v.expMis) begin
            checkOutput({v.name, " mis trans"}, 32'(dmTrans), 32'd0);
            checkOutput({v.name, " mis valid"}, 32'(rspValid), 32'd1);
            checkOutput({v.name, " mis err"}, 32'(rspErr), 32'd1);
            checkOutput({v.name, " mis flag"}, 32'(rspMis), 32'd1);
        end else begin
            checkOutput({v.name, " addr trans"}, 32'(dmTrans), 32'd1);
            checkOutput({v.name, " addr wrreq"}, 32'(dmWrReq), 32'(v.we));
            checkOutput({v.name, " addr dmaddr"}, dmAddr, {v.addr[31:2], 2'b00});
            checkOutput({v.name, " addr mask"}, 32'(dmMask), 32'(v.expMask));
            if (v.we) checkOutput({v.name, " addr dmdata"}, dmData, v.expDmdata);
            checkOutput({v.name, " addr stall"}, 32'(stall), 32'd1);
            checkOutput({v.name, " addr ready"}, 32'(memReady), 32'd0);
            step();
            checkOutput({v.name, " data trans"}, 32'(dmTrans), 32'd0);
            checkOutput({v.name, " data wrreq"}, 32'(dmWrReq), 32'd0);
            checkOutput({v.name, " data mask"}, 32'(dmMask), 32'(v.expMask));
            checkOutput({v.name, " data dmaddr"}, dmAddr, {v.addr[31:2], 2'b00});
            for (int i = 0; i < v.waits; i++) begin
                ahbReady = 1'b0;
                step();
                checkOutput({v.name, " wait valid"}, 32'(rspValid), 32'd0);
            end
            ahbReady = 1'b1; ahbResp = v.resp;
            step();
            ahbReady = 1'b0; ahbResp = 1'b0;
            checkOutput({v.name, " resp valid"}, 32'(rspValid), 32'd1);
            checkOutput({v.name, " resp rdata"}, rspRdata, v.expRdata);
            checkOutput({v.name, " resp err"}, 32'(rspErr), 32'(v.expErr));
            checkOutput({v.name, " resp mis"}, 32'(rspMis), 32'd0);
            checkOutput({v.name, " resp stall"}, 32'(stall), 32'd1);
        end
        step();
        checkOutput({v.name, " back valid"}, 32'(rspValid), 32'd0);
        checkOutput({v.name, " back ready"}, 32'(memReady), 32'd1);
        checkOutput({v.name, " back rdata"}, rspRdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dataCycles;
        rstN = 1'b0; memReq = 1'b0; memWe = 1'b0; memSize = 2'b00; memUnsigned = 1'b0;
        memAddr = '0; memWdata = '0; ahbReady = 1'b0; ahbResp = 1'b0; busRdata = '0;

        vecs[0]  = mk("LW100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,      32'hDEADBEEF, 0, 1'b0, 4'b0000, 32'h0,      32'hDEADBEEF, 1'b0, 1'b0);
        vecs[1]  = mk("LB203",  1'b0, 2'b00, 1'b0, 32'h203, 32'h0,      32'h80123456, 0, 1'b0, 4'b0000, 32'h0,      32'hFFFFFF80, 1'b0, 1'b0);
        vecs[2]  = mk("LBU203", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0,      32'h80123456, 0, 1'b0, 4'b0000, 32'h0,      32'h00000080, 1'b0, 1'b0);
        vecs[3]  = mk("SH402",  1'b1, 2'b01, 1'b0, 32'h402, 32'h1234,   32'h0,        0, 1'b0, 4'b1100, 32'h12341234, 32'h0,      1'b0, 1'b0);
        vecs[4]  = mk("SB001",  1'b1, 2'b00, 1'b0, 32'h001, 32'h55AB,   32'h0,        1, 1'b0, 4'b0010, 32'hABABABAB, 32'h0,      1'b0, 1'b0);
        vecs[5]  = mk("SW010",  1'b1, 2'b10, 1'b0, 32'h010, 32'hCAFEF00D, 32'h0,      2, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0,      1'b0, 1'b0);
        vecs[6]  = mk("LW101",  1'b0, 2'b10, 1'b0, 32'h101, 32'h0,      32'h0,        0, 1'b0, 4'b0000, 32'h0,      32'h0,        1'b1, 1'b1);
        vecs[7]  = mk("SH003",  1'b1, 2'b01, 1'b0, 32'h003, 32'h1234,   32'h0,        0, 1'b0, 4'b0000, 32'h0,      32'h0,        1'b1, 1'b1);
        vecs[8]  = mk("LHU202", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0,      32'hBEEF1234, 3, 1'b0, 4'b0000, 32'h0,      32'h0000BEEF, 1'b0, 1'b0);
        vecs[9]  = mk("LWERR",  1'b0, 2'b10, 1'b0, 32'h300, 32'h0,      32'h11111111, 0, 1'b1, 4'b0000, 32'h0,      32'h0,        1'b1, 1'b0);
        vecs[10] = mk("LH200",  1'b0, 2'b01, 1'b0, 32'h200, 32'h0,      32'h00008001, 1, 1'b0, 4'b0000, 32'h0,      32'hFFFF8001, 1'b0, 1'b0);
        vecs[11] = mk("LWLAST", 1'b0, 2'b11, 1'b0, 32'h600, 32'h0,      32'h5A5A5A5A, 15, 1'b0, 4'b0000, 32'h0,     32'h5A5A5A5A, 1'b0, 1'b0);

        repeat (3) step();
        checkOutput("reset ready", 32'(memReady), 32'd1);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset valid", 32'(rspValid), 32'd0);
        checkOutput("reset trans", 32'(dmTrans), 32'd0);
        checkOutput("reset mask", 32'(dmMask), 32'd0);
        checkOutput("reset dmaddr", dmAddr, 32'h0);
        checkOutput("reset lusize", 32'(luSize), 32'd0);
        checkOutput("reset luaddr", 32'(luAddrLo), 32'd0);
        rstN = 1'b1;
        step();

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Ready never arrives: expect abort after exactly 16 DATA cycles.
        memReq = 1'b1; memWe = 1'b0; memSize = 2'b10; memUnsigned = 1'b0; memAddr = 32'h500;
        busRdata = 32'h77777777;
        step();
        memReq = 1'b0;
        checkOutput("timeout addr trans", 32'(dmTrans), 32'd1);
        dataCycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rspValid) break;
            dataCycles++;
        end
        checkOutput("timeout data cycles", 32'(dataCycles), 32'd16);
        checkOutput("timeout valid", 32'(rspValid), 32'd1);
        checkOutput("timeout err", 32'(rspErr), 32'd1);
        checkOutput("timeout rdata", rspRdata, 32'h0);
        checkOutput("timeout mis", 32'(rspMis), 32'd0);
        step();
        checkOutput("timeout back ready", 32'(memReady), 32'd1);

        // Reset asserted mid-transfer, then a late ready must not produce a response.
        memReq = 1'b1; memWe = 1'b0; memSize = 2'b10; memAddr = 32'h700;
        step();
        memReq = 1'b0;
        step();
        checkOutput("rst in data stall", 32'(stall), 32'd1);
        rstN = 1'b0;
        step();
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst ready", 32'(memReady), 32'd1);
        checkOutput("rst valid", 32'(rspValid), 32'd0);
        checkOutput("rst lusize", 32'(luSize), 32'd0);
        rstN = 1'b1; ahbReady = 1'b1;
        step();
        checkOutput("late ready valid", 32'(rspValid), 32'd0);
        checkOutput("late ready stall", 32'(stall), 32'd0);
        ahbReady = 1'b0;
        step();
        checkOutput("late ready idle", 32'(memReady), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
